// File: rtl/prog_loader.sv
// Program-memory writer for CPUC: takes a framed chunk stream, assembles configuration words and writes them sequentially.
// Optional trailing XOR checksum chunk is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int W  = 8,
  parameter int CW = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          pm_we,
  output logic [AW-1:0] pm_addr,
  output logic [CW-1:0] pm_wdata,
  output logic          cpu_hold,
  output logic [W-1:0]  start_pc,
  output logic          done,
  output logic          err,
  output logic [2:0]    fsm_state
);

  localparam int K     = (CW + W - 1) / W;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int SW    = AW + W + 1;
  localparam logic [SW-1:0] LIMIT = SW'(1) << AW;

  typedef enum logic [2:0] {
    ST_ADDR  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_ERR   = 3'd5,
    ST_CSUM  = 3'd6
`else
    ST_ERR   = 3'd5
`endif
  } state_t;

  state_t           state;
  logic [AW-1:0]    addr;
  logic [W-1:0]     words_left;
  logic [CNT_W-1:0] chunk_cnt;
  logic [K*W-1:0]   word_buf;
  logic [K*W-1:0]   word_buf_next;
  logic [SW-1:0]    range_sum;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [W-1:0]     csum;
`endif

  assign fsm_state = state;

  // Transfer happens on in_valid && in_ready; in_ready is a pure state decode, gated low during reset.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      case (state)
        ST_ADDR, ST_COUNT, ST_DATA: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM:                    in_ready = 1'b1;
`endif
        default:                    in_ready = 1'b0;
      endcase
    end
  end

  // First chunk of a word lands in the least significant bits.
  always_comb begin
    word_buf_next = word_buf;
    word_buf_next[chunk_cnt*W +: W] = in_data;
  end

  assign range_sum = SW'(addr) + SW'(in_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_ADDR;
      addr       <= '0;
      words_left <= '0;
      chunk_cnt  <= '0;
      word_buf   <= '0;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      cpu_hold   <= 1'b1;
      start_pc   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        ST_ADDR: begin
          if (in_valid) begin
            addr     <= in_data[AW-1:0];
            start_pc <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= in_data;
`endif
            state    <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (in_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (range_sum > LIMIT) begin
              err   <= 1'b1;
              state <= ST_ERR;
            end else if (in_data == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state    <= ST_CSUM;
`else
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= ST_DONE;
`endif
            end else begin
              words_left <= in_data;
              chunk_cnt  <= '0;
              state      <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (in_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            word_buf <= word_buf_next;
            if (chunk_cnt == CNT_W'(K - 1)) begin
              chunk_cnt <= '0;
              pm_we     <= 1'b1;
              pm_addr   <= addr;
              pm_wdata  <= word_buf_next[CW-1:0];
              state     <= ST_WRITE;
            end else begin
              chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
          end
        end
        ST_WRITE: begin
          pm_we      <= 1'b0;
          addr       <= addr + AW'(1);
          words_left <= words_left - W'(1);
          if (words_left == W'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state    <= ST_CSUM;
`else
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= ST_DONE;
`endif
          end else begin
            state <= ST_DATA;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        // Words already written stay in memory; a bad checksum only keeps the CPU held.
        ST_CSUM: begin
          if (in_valid) begin
            if (in_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= ST_DONE;
            end else begin
              err   <= 1'b1;
              state <= ST_ERR;
            end
          end
        end
`endif
        ST_DONE: state <= ST_DONE;
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with W=8, CW=20, AW=4 (K=3): cycle table for the basic frame plus handshake/error/reset sequences.
module tb_prog_loader;
  localparam int W  = 8;
  localparam int CW = 20;
  localparam int AW = 4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [CW-1:0] pm_wdata;
  logic          cpu_hold;
  logic [W-1:0]  start_pc;
  logic          done;
  logic          err;
  logic [2:0]    fsm_state;

  prog_loader #(.W(W), .CW(CW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_hold(cpu_hold), .start_pc(start_pc), .done(done), .err(err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int tx_cnt   = 0;
  // {transfer count at write, addr, data}
  logic [31:0] exp_q[$];

  typedef struct {
    logic          v;
    logic [7:0]    d;
    logic          rdy;
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] wdata;
    logic          dn;
    logic          er;
    logic          hold;
    logic [7:0]    spc;
  } row_t;
  row_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // scoreboard: transfer counter and write monitor
  always @(posedge clk) begin
    if (reset && in_valid && in_ready) tx_cnt++;
  end

  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h:%h expected=none", pm_addr, pm_wdata);
      end else begin
        chk("write", {tx_cnt[7:0], pm_addr, pm_wdata}, exp_q.pop_front());
      end
    end
  end

  function automatic row_t mk(logic v, logic [7:0] d, logic rdy, logic we, logic [AW-1:0] a,
                              logic [CW-1:0] wd, logic dn, logic er, logic hold, logic [7:0] spc);
    row_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = a; r.wdata = wd;
    r.dn = dn; r.er = er; r.hold = hold; r.spc = spc;
    return r;
  endfunction

  // driver tasks
  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdy"},   in_ready, 0);
    chk({tag, "_we"},    pm_we, 0);
    chk({tag, "_addr"},  pm_addr, 0);
    chk({tag, "_wdata"}, pm_wdata, 0);
    chk({tag, "_hold"},  cpu_hold, 1);
    chk({tag, "_spc"},   start_pc, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    reset = 1'b1;
    tx_cnt = 0;
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    int tries;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    tries = 0;
    while (in_ready !== 1'b1 && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_ready expected=ready data=%h", d);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL wait_end_timeout actual=no_done expected=done_or_err");
    end
  endtask

  task automatic check_final(input string tag, input logic dn, input logic er, input logic hold,
                             input logic [7:0] spc);
    chk({tag, "_done"}, done, dn);
    chk({tag, "_err"},  err, er);
    chk({tag, "_hold"}, cpu_hold, hold);
    chk({tag, "_spc"},  start_pc, spc);
    chk({tag, "_rdy"},  in_ready, 0);
  endtask

  task automatic send_frame1(input int gap);
    logic [7:0] s[8];
    s = '{8'h02, 8'h02, 8'h45, 8'h23, 8'h01, 8'hDE, 8'hBC, 8'h0A};
    for (int i = 0; i < 8; i++) send(s[i], gap);
  endtask

  task automatic push_frame1_writes();
    exp_q.push_back({8'd5, 4'd2, 20'h12345});
    exp_q.push_back({8'd8, 4'd3, 20'hABCDE});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    #2 reset = 1'b0;
    #1 check_reset_vals("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Frame 1 cycle by cycle, in_valid held high
    tbl.push_back(mk(1, 8'h02, 1, 0, 4'd0, 20'h00000, 0, 0, 1, 8'h00));
    tbl.push_back(mk(1, 8'h02, 1, 0, 4'd0, 20'h00000, 0, 0, 1, 8'h02));
    tbl.push_back(mk(1, 8'h45, 1, 0, 4'd0, 20'h00000, 0, 0, 1, 8'h02));
    tbl.push_back(mk(1, 8'h23, 1, 0, 4'd0, 20'h00000, 0, 0, 1, 8'h02));
    tbl.push_back(mk(1, 8'h01, 1, 0, 4'd0, 20'h00000, 0, 0, 1, 8'h02));
    tbl.push_back(mk(1, 8'hDE, 0, 1, 4'd2, 20'h12345, 0, 0, 1, 8'h02));
    tbl.push_back(mk(1, 8'hDE, 1, 0, 4'd2, 20'h12345, 0, 0, 1, 8'h02));
    tbl.push_back(mk(1, 8'hBC, 1, 0, 4'd2, 20'h12345, 0, 0, 1, 8'h02));
    tbl.push_back(mk(1, 8'h0A, 1, 0, 4'd2, 20'h12345, 0, 0, 1, 8'h02));
    tbl.push_back(mk(CS, 8'h0F, 0, 1, 4'd3, 20'hABCDE, 0, 0, 1, 8'h02));
    tbl.push_back(mk(CS, 8'h0F, CS, 0, 4'd3, 20'hABCDE, !CS, 0, CS, 8'h02));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 4'd3, 20'hABCDE, 1, 0, 0, 8'h02));

    do_reset();
    push_frame1_writes();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      chk($sformatf("t%0d_rdy", i),   in_ready, tbl[i].rdy);
      chk($sformatf("t%0d_we", i),    pm_we,    tbl[i].we);
      chk($sformatf("t%0d_addr", i),  pm_addr,  tbl[i].addr);
      chk($sformatf("t%0d_wdata", i), pm_wdata, tbl[i].wdata);
      chk($sformatf("t%0d_done", i),  done,     tbl[i].dn);
      chk($sformatf("t%0d_err", i),   err,      tbl[i].er);
      chk($sformatf("t%0d_hold", i),  cpu_hold, tbl[i].hold);
      chk($sformatf("t%0d_spc", i),   start_pc, tbl[i].spc);
    end
    idle();
    chk("t_missing_writes", exp_q.size(), 0);

    // Frame 1 with in_valid every other cycle
    do_reset();
    push_frame1_writes();
    send_frame1(1);
    if (CS) send(8'h0F, 1);
    idle();
    wait_end(40);
    check_final("gap", 1, 0, 0, 8'h02);
    chk("gap_missing_writes", exp_q.size(), 0);

    // Zero word count
    do_reset();
    send(8'h05, 0);
    send(8'h00, 0);
    if (CS) send(8'h05, 0);
    idle();
    check_final("zero1", 1, 0, 0, 8'h05);
    @(negedge clk);
    check_final("zero2", 1, 0, 0, 8'h05);

    // Out of range: 0x0E + 3 > 16
    do_reset();
    send(8'h0E, 0);
    send(8'h03, 0);
    idle();
    check_final("range", 0, 1, 1, 8'h0E);
    chk("range_we", pm_we, 0);
    in_valid = 1'b1;
    in_data  = 8'h33;
    repeat (2) @(negedge clk);
    check_final("range_hold", 0, 1, 1, 8'h0E);
    in_valid = 1'b0;

    // Reset in the middle of a word
    do_reset();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    check_reset_vals("midrst_hold");
    in_valid = 1'b0;
    reset = 1'b1;
    tx_cnt = 0;
    push_frame1_writes();
    send_frame1(0);
    if (CS) send(8'h0F, 0);
    idle();
    wait_end(40);
    check_final("midrst_end", 1, 0, 0, 8'h02);
    chk("midrst_missing_writes", exp_q.size(), 0);

    // Bad checksum: writes land, CPU stays held
    if (CS) begin
      do_reset();
      push_frame1_writes();
      send_frame1(0);
      send(8'h0E, 0);
      idle();
      wait_end(40);
      check_final("badcsum", 0, 1, 1, 8'h02);
      chk("badcsum_missing_writes", exp_q.size(), 0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
